// File: rtl/torus_router_sync_if.sv
// Router-side port bundle: five flattened packet lanes with valid/ready plus the error pulse.
// With ROUTER_STATS_EN defined, per-output packet counters are added to the bundle.
interface torus_router_sync_if #(
  parameter int WIDTH_PACKAGE = 33
);
  logic [5*WIDTH_PACKAGE-1:0] in_data;
  logic [4:0]                 in_valid;
  logic [4:0]                 in_ready;
  logic [5*WIDTH_PACKAGE-1:0] out_data;
  logic [4:0]                 out_valid;
  logic [4:0]                 out_ready;
  logic                       addr_err;
`ifdef ROUTER_STATS_EN
  logic [5*16-1:0]            pkt_count;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, addr_err, pkt_count);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, addr_err, pkt_count);
`else
  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, addr_err);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, addr_err);
`endif
endinterface

// File: rtl/torus_router_sync.sv
// 2-D torus router node: input FIFOs, X-then-Y shortest-path routing, round-robin output regs.
// Latency 1 cycle FIFO-to-output when uncontended; an output held by !out_ready stalls its granted FIFO head.
// Optional ROUTER_STATS_EN adds saturating per-output delivered-packet counters (pkt_count).
module torus_router_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

module torus_router_sync #(
  parameter int WIDTH_PACKAGE = 33,
  parameter int X_BITS        = 3,
  parameter int Y_BITS        = 2,
  parameter int X_DIM         = 5,
  parameter int Y_DIM         = 3,
  parameter logic [X_BITS+Y_BITS-1:0] ROUTER_LOC = 5'b000_00,
  parameter int FIFO_DEPTH    = 4
) (
  input logic clk,
  input logic rst_n,
  torus_router_sync_if.slave bus
);
  localparam int W = WIDTH_PACKAGE;
  localparam logic [X_BITS:0] LX = {1'b0, ROUTER_LOC[X_BITS+Y_BITS-1 -: X_BITS]};
  localparam logic [Y_BITS:0] LY = {1'b0, ROUTER_LOC[Y_BITS-1:0]};
  localparam logic [X_BITS:0] XD = (X_BITS+1)'(X_DIM);
  localparam logic [Y_BITS:0] YD = (Y_BITS+1)'(Y_DIM);
  localparam logic [X_BITS:0] XH = (X_BITS+1)'(X_DIM / 2);
  localparam logic [Y_BITS:0] YH = (Y_BITS+1)'(Y_DIM / 2);

  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
  } dest_t;

  logic [W-1:0]    head [5];
  logic [4:0]      fifo_full, fifo_empty, push, pop;
  dest_t           dst [5];
  logic [X_BITS:0] dx [5];
  logic [Y_BITS:0] dy [5];
  logic [2:0]      route [5];
  logic [4:0]      bad;
  logic [4:0]      req [5];
  logic [4:0]      slot_free, gnt_vld;
  logic [2:0]      gnt_idx [5];
  logic [3:0]      cand;
  logic            err_nxt;

  logic [W-1:0]    out_dat_q [5];
  logic [4:0]      out_vld_q;
  logic [2:0]      rr_ptr [5];
  logic            addr_err_q;

  assign push         = bus.in_valid & ~fifo_full;
  assign bus.in_ready = ~fifo_full;

  for (genvar i = 0; i < 5; i++) begin : g_in
    torus_router_sync_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[i]),
      .push_dat (bus.in_data[i*W +: W]),
      .pop      (pop[i]),
      .head_dat (head[i]),
      .full     (fifo_full[i]),
      .empty    (fifo_empty[i])
    );
    assign bus.out_data[i*W +: W] = out_dat_q[i];
  end

  // Ring distances are taken modulo the torus size so the shorter direction can be picked.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      dst[i] = dest_t'(head[i][W-1 -: X_BITS+Y_BITS]);
      bad[i] = ({1'b0, dst[i].x} >= XD) || ({1'b0, dst[i].y} >= YD);
      if ({1'b0, dst[i].x} >= LX) dx[i] = {1'b0, dst[i].x} - LX;
      else                        dx[i] = {1'b0, dst[i].x} + XD - LX;
      if ({1'b0, dst[i].y} >= LY) dy[i] = {1'b0, dst[i].y} - LY;
      else                        dy[i] = {1'b0, dst[i].y} + YD - LY;
      if (bad[i])         route[i] = 3'd0;
      else if (dx[i] != '0) route[i] = (dx[i] <= XH) ? 3'd2 : 3'd1;
      else if (dy[i] != '0) route[i] = (dy[i] <= YH) ? 3'd4 : 3'd3;
      else                  route[i] = 3'd0;
      req[i] = fifo_empty[i] ? 5'b0 : (5'b1 << route[i]);
    end
  end

  assign slot_free = ~out_vld_q | bus.out_ready;

  // Search starts one past the last winner, so the previous winner has lowest priority.
  always_comb begin
    cand    = '0;
    gnt_vld = '0;
    for (int o = 0; o < 5; o++) begin
      gnt_idx[o] = '0;
      if (slot_free[o]) begin
        for (int k = 1; k <= 5; k++) begin
          cand = {1'b0, rr_ptr[o]} + 4'(k);
          if (cand >= 4'd5) cand = cand - 4'd5;
          if (!gnt_vld[o] && req[cand[2:0]][o]) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = cand[2:0];
          end
        end
      end
    end
  end

  always_comb begin
    pop     = '0;
    err_nxt = 1'b0;
    for (int o = 0; o < 5; o++) begin
      if (gnt_vld[o]) begin
        pop[gnt_idx[o]] = 1'b1;
        if (bad[gnt_idx[o]]) err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= '0;
      addr_err_q <= 1'b0;
      for (int o = 0; o < 5; o++) begin
        out_dat_q[o] <= '0;
        rr_ptr[o]    <= 3'd4;
      end
    end else begin
      addr_err_q <= err_nxt;
      for (int o = 0; o < 5; o++) begin
        if (gnt_vld[o]) begin
          out_dat_q[o] <= head[gnt_idx[o]];
          out_vld_q[o] <= 1'b1;
          rr_ptr[o]    <= gnt_idx[o];
        end else if (bus.out_ready[o]) begin
          out_vld_q[o] <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.addr_err  = addr_err_q;

`ifdef ROUTER_STATS_EN
  logic [15:0] pkt_cnt [5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < 5; o++) pkt_cnt[o] <= '0;
    end else begin
      for (int o = 0; o < 5; o++)
        if (out_vld_q[o] && bus.out_ready[o] && pkt_cnt[o] != 16'hFFFF)
          pkt_cnt[o] <= pkt_cnt[o] + 16'd1;
    end
  end

  for (genvar o = 0; o < 5; o++) begin : g_stats
    assign bus.pkt_count[o*16 +: 16] = pkt_cnt[o];
  end
`endif
endmodule
